a23_wb_cmd_master: RTL and testbench
====================================

A23_WB_CMD_MASTER -- requirements
Module: a23_wb_cmd_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 255, max cycles stb held unacknowledged before abort (1..65535).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: globrst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: i_cmd_valid  input  1  command present.
REQ-005 SHALL have port: o_cmd_ready  output  1  command can be accepted.
REQ-006 SHALL have port: i_cmd_we  input  1  1=write, 0=read.
REQ-007 SHALL have port: i_cmd_adr  input  32  byte address.
REQ-008 SHALL have port: i_cmd_dat  input  32  write data.
REQ-009 SHALL have port: i_cmd_sel  input  4  byte lanes.
REQ-010 SHALL have port: o_rsp_valid  output  1  response present.
REQ-011 SHALL have port: i_rsp_ready  input  1  response consumed.
REQ-012 SHALL have port: o_rsp_dat  output  32  read data (0 for writes, errors, timeouts).
REQ-013 SHALL have port: o_rsp_err  output  1  transfer ended by i_wb_err.
REQ-014 SHALL have port: o_rsp_timeout  output  1  transfer ended by timeout.
REQ-015 SHALL have ports: o_wb_adr 32, o_wb_sel 4, o_wb_we 1, o_wb_dat 32, o_wb_cyc 1, o_wb_stb 1 (outputs); i_wb_dat 32, i_wb_ack 1, i_wb_err 1 (inputs); classic Wishbone initiator.
REQ-016 SHALL have port: o_txn_count  output  16  count of completed transfers, wraps 0xFFFF->0.

Function
REQ-017 SHALL implement states IDLE, BUS, RESP; o_cmd_ready = (state==IDLE), combinational from state only.
REQ-018 IDLE: on i_cmd_valid && o_cmd_ready at an edge, SHALL register adr/sel/we/dat onto o_wb_*, set o_wb_cyc=o_wb_stb=1, clear timeout counter, go BUS; stb asserted the cycle after acceptance.
REQ-019 BUS: o_wb_adr/sel/we/dat SHALL remain stable while stb is high.
REQ-020 BUS: i_wb_ack or i_wb_err sampled high at an edge SHALL terminate: cyc/stb low next cycle, go RESP, o_rsp_valid=1.
REQ-021 i_wb_err and i_wb_ack high together SHALL be treated as error (err wins, o_rsp_dat=0, o_rsp_err=1).
REQ-022 Read terminated by ack SHALL capture i_wb_dat into o_rsp_dat on that edge; write ack SHALL set o_rsp_dat=0.
REQ-023 Timeout counter SHALL increment each BUS cycle without ack/err; at TIMEOUT unacknowledged cycles SHALL terminate as in REQ-020 with o_rsp_timeout=1, o_rsp_err=0, o_rsp_dat=0.
REQ-024 Ack arriving on the same edge the counter reaches TIMEOUT SHALL win (normal completion).
REQ-025 RESP: o_rsp_* SHALL hold stable until i_rsp_ready sampled high; then o_rsp_valid=0 and return IDLE; new command accepted no earlier than the following edge.
REQ-026 o_txn_count SHALL increment once per BUS termination (ack, err or timeout).
REQ-027 i_wb_ack/i_wb_err in IDLE or RESP SHALL be ignored.
REQ-028 i_cmd_* SHALL be ignored outside IDLE.
REQ-029 Minimum transfer latency: acceptance edge to o_rsp_valid = 2 edges with zero-wait slave.

Reset
REQ-030 globrst high at an edge SHALL force IDLE, o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_adr=o_wb_dat=0, o_wb_sel=0, o_rsp_valid=0, o_rsp_dat=0, o_rsp_err=o_rsp_timeout=0, o_txn_count=0, timeout counter 0.
REQ-031 Reset mid-BUS SHALL drop cyc/stb at that edge with no response produced; reset has priority over all other events.

Verification
REQ-032 Write: cmd we=1 adr=0x100 dat=0xDEADBEEF sel=0xF, slave acks in stb cycle -> one stb cycle, rsp_valid with dat=0, err=0, count=1, memory[0x40]=0xDEADBEEF.
REQ-033 Read: cmd we=0 adr=0x100, slave acks one cycle after stb -> stb high 2 cycles, rsp_dat=0xDEADBEEF.
REQ-034 Error: slave asserts err and ack same cycle on read -> rsp_err=1, rsp_dat=0, timeout=0.
REQ-035 Timeout: TIMEOUT=4, slave never acks -> stb high exactly 4 cycles, rsp_timeout=1, count increments.
REQ-036 Backpressure: i_rsp_ready low 10 cycles -> rsp held stable, cmd_ready low throughout, no new stb.
REQ-037 Reset mid-BUS then valid read -> cyc low after reset edge, no response, count=0; subsequent read completes normally.

Source files
------------

// File: rtl/a23_wb_cmd_master.sv
// Command-to-Wishbone initiator: accepts one command at a time, runs a
// single classic Wishbone cycle, and presents the response until it is
// consumed. A cycle that is neither acked nor errored within TIMEOUT stb
// cycles is aborted and reported as a timeout.
//
// state | meaning
// IDLE  | ready for a command, bus idle
// BUS   | cyc/stb asserted, waiting for ack/err or timeout
// RESP  | response valid, waiting for i_rsp_ready
module a23_wb_cmd_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        globrst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [31:0] i_cmd_adr,
  input  logic [31:0] i_cmd_dat,
  input  logic [3:0]  i_cmd_sel,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_dat,
  output logic        o_rsp_err,
  output logic        o_rsp_timeout,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic [15:0] o_txn_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter value seen on the edge that completes the TIMEOUT-th idle stb cycle.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_tmo_q, rsp_tmo_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] cnt_q, cnt_d;

  // State and datapath registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (globrst) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_tmo_q <= 1'b0;
      tmo_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      rsp_tmo_q <= rsp_tmo_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and capture logic; err beats ack, ack beats timeout.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    rsp_tmo_d = rsp_tmo_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          adr_d   = i_cmd_adr;
          dat_d   = i_cmd_dat;
          sel_d   = i_cmd_sel;
          we_d    = i_cmd_we;
          tmo_d   = '0;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (i_wb_err) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          rsp_tmo_d = 1'b0;
          cnt_d     = cnt_q + 16'd1;
          state_d   = ST_RESP;
        end else if (i_wb_ack) begin
          rsp_dat_d = we_q ? 32'd0 : i_wb_dat;
          rsp_err_d = 1'b0;
          rsp_tmo_d = 1'b0;
          cnt_d     = cnt_q + 16'd1;
          state_d   = ST_RESP;
        end else if (tmo_q == TMO_LAST) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b0;
          rsp_tmo_d = 1'b1;
          cnt_d     = cnt_q + 16'd1;
          state_d   = ST_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_cmd_ready   = (state_q == ST_IDLE);
  assign o_wb_cyc      = (state_q == ST_BUS);
  assign o_wb_stb      = (state_q == ST_BUS);
  assign o_rsp_valid   = (state_q == ST_RESP);
  assign o_wb_adr      = adr_q;
  assign o_wb_dat      = dat_q;
  assign o_wb_sel      = sel_q;
  assign o_wb_we       = we_q;
  assign o_rsp_dat     = rsp_dat_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_rsp_timeout = rsp_tmo_q;
  assign o_txn_count   = cnt_q;

endmodule

// File: tb/tb_a23_wb_cmd_master.sv
// Bench for a23_wb_cmd_master: a word-addressed memory slave with a
// programmable wait count and termination mode, and a transaction-level
// reference model that predicts response kind, stb duration and data.
module tb_a23_wb_cmd_master;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        globrst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_we = 1'b0;
  logic [31:0] i_cmd_adr = '0;
  logic [31:0] i_cmd_dat = '0;
  logic [3:0]  i_cmd_sel = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_dat;
  logic        o_rsp_err;
  logic        o_rsp_timeout;
  logic [31:0] o_wb_adr;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic [31:0] o_wb_dat;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic [15:0] o_txn_count;

  int checks = 0;
  int errors = 0;

  // slave: mode 0 = ack, 1 = err, 2 = ack+err, 3 = never respond
  int   slv_mode = 3;
  int   slv_wait = 0;
  int   stb_cnt  = 0;
  logic spur_ack = 1'b0;
  logic spur_err = 1'b0;
  logic [31:0] mem       [0:255];
  logic [31:0] model_mem [0:255];
  logic [15:0] model_cnt = '0;

  a23_wb_cmd_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .globrst(globrst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_we(i_cmd_we), .i_cmd_adr(i_cmd_adr), .i_cmd_dat(i_cmd_dat),
    .i_cmd_sel(i_cmd_sel),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_dat(o_rsp_dat), .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_dat(o_wb_dat), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_txn_count(o_txn_count)
  );

  always #5 clk = ~clk;

  assign i_wb_ack = spur_ack | (o_wb_stb && (slv_mode == 0 || slv_mode == 2) && stb_cnt == slv_wait);
  assign i_wb_err = spur_err | (o_wb_stb && (slv_mode == 1 || slv_mode == 2) && stb_cnt == slv_wait);
  assign i_wb_dat = mem[o_wb_adr[9:2]];

  always @(posedge clk) begin
    if (o_wb_stb) stb_cnt <= stb_cnt + 1;
    else          stb_cnt <= 0;
    if (o_wb_stb && i_wb_ack && !i_wb_err && o_wb_we)
      for (int b = 0; b < 4; b++)
        if (o_wb_sel[b]) mem[o_wb_adr[9:2]][b*8 +: 8] <= o_wb_dat[b*8 +: 8];
  end

  // One command from issue to consumption, checked against the model.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int mode, input int wt, input int hold);
    int exp_stb, nstb, kind;   // kind: 0 ok, 1 err, 2 timeout
    logic [31:0] exp_dat;
    logic [31:0] held_dat;
    bit got;
    if (mode == 3 || wt >= TMO) begin kind = 2; exp_stb = TMO; end
    else begin kind = (mode == 0) ? 0 : 1; exp_stb = wt + 1; end
    exp_dat = (kind == 0 && !we) ? model_mem[adr[9:2]] : 32'd0;
    if (kind == 0 && we)
      for (int b = 0; b < 4; b++)
        if (sel[b]) model_mem[adr[9:2]][b*8 +: 8] = dat[b*8 +: 8];
    model_cnt = model_cnt + 16'd1;

    @(negedge clk);
    slv_mode = mode; slv_wait = wt;
    i_cmd_we = we; i_cmd_adr = adr; i_cmd_dat = dat; i_cmd_sel = sel; i_cmd_valid = 1'b1;
    checks++;
    if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_idle: got %b want 1", o_cmd_ready); end
    @(negedge clk);
    nstb = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      i_cmd_valid = 1'($urandom); i_cmd_adr = $urandom; i_cmd_dat = $urandom;
      i_cmd_we = 1'($urandom); i_cmd_sel = 4'($urandom);
      if (o_wb_stb) begin
        nstb++;
        checks++;
        if (o_wb_adr !== adr || o_wb_dat !== dat || o_wb_sel !== sel || o_wb_we !== we || o_wb_cyc !== 1'b1 || o_cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL bus_stable: adr %h dat %h sel %h we %b cyc %b rdy %b want adr %h dat %h sel %h we %b cyc 1 rdy 0",
                   o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_cmd_ready, adr, dat, sel, we);
        end
      end
      if (o_rsp_valid) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rsp_wait: no response within 40 cycles"); end
    checks++;
    if (nstb !== exp_stb) begin errors++; $display("FAIL stb_cycles: got %0d want %0d", nstb, exp_stb); end
    checks++;
    if (o_rsp_dat !== exp_dat || o_rsp_err !== (kind == 1) || o_rsp_timeout !== (kind == 2) || o_wb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL rsp_fields: dat %h err %b tmo %b cyc %b want dat %h err %b tmo %b cyc 0",
               o_rsp_dat, o_rsp_err, o_rsp_timeout, o_wb_cyc, exp_dat, kind == 1, kind == 2);
    end
    checks++;
    if (o_txn_count !== model_cnt) begin errors++; $display("FAIL txn_count: got %0d want %0d", o_txn_count, model_cnt); end
    held_dat = o_rsp_dat;
    for (int h = 0; h < hold; h++) begin
      spur_ack = 1'($urandom); spur_err = 1'($urandom);
      i_cmd_valid = 1'($urandom); i_cmd_adr = $urandom;
      @(negedge clk);
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_dat !== held_dat || o_cmd_ready !== 1'b0 || o_wb_stb !== 1'b0 || o_txn_count !== model_cnt) begin
        errors++;
        $display("FAIL rsp_hold: valid %b dat %h rdy %b stb %b cnt %0d want 1 %h 0 0 %0d",
                 o_rsp_valid, o_rsp_dat, o_cmd_ready, o_wb_stb, o_txn_count, held_dat, model_cnt);
      end
    end
    spur_ack = 1'b0; spur_err = 1'b0; i_cmd_valid = 1'b0; i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_wb_stb !== 1'b0) begin
      errors++;
      $display("FAIL rsp_release: valid %b rdy %b stb %b want 0 1 0", o_rsp_valid, o_cmd_ready, o_wb_stb);
    end
  endtask

  task automatic test_reset();
    globrst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_wb_cyc !== 0 || o_wb_stb !== 0 || o_wb_we !== 0 || o_wb_adr !== 0 || o_wb_dat !== 0 ||
        o_wb_sel !== 0 || o_rsp_valid !== 0 || o_rsp_dat !== 0 || o_rsp_err !== 0 ||
        o_rsp_timeout !== 0 || o_txn_count !== 0 || o_cmd_ready !== 1) begin
      errors++;
      $display("FAIL reset_state: cyc %b stb %b we %b adr %h dat %h sel %h rv %b rd %h re %b rt %b cnt %0d rdy %b want all 0, rdy 1",
               o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel, o_rsp_valid,
               o_rsp_dat, o_rsp_err, o_rsp_timeout, o_txn_count, o_cmd_ready);
    end
    globrst = 1'b0;
    model_cnt = '0;
  endtask

  task automatic test_write();
    do_txn(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    checks++;
    if (mem[8'h40] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_mem: got %h want deadbeef", mem[8'h40]); end
  endtask

  task automatic test_read();
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, 0, 1, 0);
  endtask

  task automatic test_error();
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, 2, 0, 0);
    do_txn(1'b1, 32'h104, 32'h12345678, 4'h3, 1, 2, 0);
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 32'h200, 32'h0, 4'hF, 3, 0, 0);
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, 0, TMO - 1, 0);
    do_txn(1'b1, 32'h100, 32'h0, 4'hF, 0, TMO, 0);
  endtask

  task automatic test_backpressure();
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, 0, 0, 10);
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk);
    slv_mode = 3; slv_wait = 0;
    i_cmd_we = 1'b0; i_cmd_adr = 32'h100; i_cmd_sel = 4'hF; i_cmd_valid = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_wb_stb !== 1'b1) begin errors++; $display("FAIL mid_bus_stb: got %b want 1", o_wb_stb); end
    globrst = 1'b1;
    @(negedge clk);
    globrst = 1'b0;
    model_cnt = '0;
    checks++;
    if (o_wb_cyc !== 0 || o_wb_stb !== 0 || o_rsp_valid !== 0 || o_txn_count !== 0) begin
      errors++;
      $display("FAIL mid_bus_reset: cyc %b stb %b rv %b cnt %0d want 0 0 0 0", o_wb_cyc, o_wb_stb, o_rsp_valid, o_txn_count);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (o_rsp_valid !== 0 || o_wb_stb !== 0) begin
        errors++; $display("FAIL post_reset_quiet: rv %b stb %b want 0 0", o_rsp_valid, o_wb_stb);
      end
    end
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int m;
      a = {22'($urandom_range(0, 3)), 8'($urandom), 2'b00};
      m = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 3);
      do_txn(1'($urandom), a, $urandom, 4'($urandom), m, $urandom_range(0, 5), $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      model_mem[i] = mem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_error();
    test_timeout();
    test_backpressure();
    test_reset_mid_bus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
